// File: rtl/jtopl3_mmr_if.sv
// Host bus of the OPL register front-end.
// Carries data, strobe, address select and FIFO status.
interface jtopl3_mmr_if;
    logic [7:0] din;
    logic       write;
    logic [1:0] addr;
    logic       busy;
    logic       ovf;

    modport master (output din, write, addr, input busy, ovf);
    modport slave  (input din, write, addr, output busy, ovf);
endinterface

// File: rtl/jtopl3_mmr.sv
// OPL register front-end: host writes are queued and retired one per cenop,
// then decoded into slot/channel strobes and global control registers.
module jtopl3_mmr #(
    parameter int OPL_TYPE   = 2,
    parameter int BANKS      = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cenop,
    jtopl3_mmr_if.slave host,
    output logic [7:0] din_copy,
    output logic       sel_bank,
    output logic [1:0] sel_group,
    output logic [2:0] sel_sub,
    output logic       up_mult,
    output logic       up_ksl_tl,
    output logic       up_ar_dr,
    output logic       up_sl_rr,
    output logic       up_wav,
    output logic       up_fnumlo,
    output logic       up_fnumhi,
    output logic       up_fbcon,
    output logic       rhy_en,
    output logic [4:0] rhy_kon,
    output logic       am_dep,
    output logic       vib_dep,
    output logic       wave_mode,
    output logic       new_mode,
    output logic [5:0] conn_sel,
    output logic [7:0] value_A,
    output logic [7:0] value_B,
    output logic       load_A,
    output logic       load_B,
    output logic       flagen_A,
    output logic       flagen_B,
    output logic       clr_flag_A,
    output logic       clr_flag_B
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    logic [16:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [8:0]    selreg_q, selreg_d;
    logic          busy_q, busy_d, ovf_q, ovf_d;
    logic [7:0]    din_copy_q, din_copy_d;
    logic          sel_bank_q, sel_bank_d;
    logic [1:0]    sel_group_q, sel_group_d;
    logic [2:0]    sel_sub_q, sel_sub_d;
    logic [7:0]    ups_q, ups_d;
    logic [1:0]    clr_q, clr_d;
    logic [7:0]    bd_q, bd_d;
    logic          wave_mode_q, wave_mode_d;
    logic          new_mode_q, new_mode_d;
    logic [5:0]    conn_sel_q, conn_sel_d;
    logic [7:0]    value_a_q, value_a_d, value_b_q, value_b_d;
    logic [1:0]    load_q, load_d, flagen_q, flagen_d;

    logic        push, pop, dwr, en_b, slot_hit, chan_hit;
    logic [16:0] ent;
    logic        bnk;
    logic [7:0]  r, d;

    assign dwr  = host.write && host.addr[0];
    assign push = dwr && (cnt_q != FULL);
    assign pop  = cenop && (cnt_q != '0);
    assign ent  = mem_q[rd_q];
    assign bnk  = ent[16];
    assign r    = ent[15:8];
    assign d    = ent[7:0];
    assign en_b = !bnk || new_mode_q;

    assign slot_hit = ((r >= 8'h20 && r <= 8'h9F) ||
                       (OPL_TYPE >= 2 && r >= 8'hE0)) &&
                      (r[2:0] <= 3'd5) && (r[4:3] != 2'd3);
    assign chan_hit = (r >= 8'hA0) && (r <= 8'hC8) && (r[3:0] <= 4'd8);

    always_comb begin
        selreg_d    = selreg_q;
        wr_d        = wr_q + AW'(push);
        rd_d        = rd_q + AW'(pop);
        cnt_d       = cnt_q + CW'(push) - CW'(pop);
        busy_d      = (cnt_d == FULL);
        ovf_d       = ovf_q || (dwr && cnt_q == FULL);
        din_copy_d  = din_copy_q;
        sel_bank_d  = sel_bank_q;
        sel_group_d = sel_group_q;
        sel_sub_d   = sel_sub_q;
        ups_d       = cenop ? 8'd0 : ups_q;
        clr_d       = cenop ? 2'd0 : clr_q;
        bd_d        = bd_q;
        wave_mode_d = wave_mode_q;
        new_mode_d  = new_mode_q;
        conn_sel_d  = conn_sel_q;
        value_a_d   = value_a_q;
        value_b_d   = value_b_q;
        load_d      = load_q;
        flagen_d    = flagen_q;
        if (host.write && !host.addr[0])
            selreg_d = {host.addr[1] && (BANKS == 2), host.din};
        if (pop) begin
            din_copy_d = d;
            if (OPL_TYPE == 3 && bnk && r == 8'h04) conn_sel_d = d[5:0];
            if (OPL_TYPE == 3 && bnk && r == 8'h05) new_mode_d = d[0];
            if (!bnk) begin
                case (r)
                    8'h01: if (OPL_TYPE >= 2) wave_mode_d = d[5];
                    8'h02: value_a_d = d;
                    8'h03: value_b_d = d;
                    8'h04: begin
                        clr_d = {2{d[7]}};
                        if (!d[7]) begin
                            flagen_d = {~d[5], ~d[6]};
                            load_d   = d[1:0];
                        end
                    end
                    8'hBD: bd_d = d;
                    default: ;
                endcase
            end
            if (en_b && slot_hit) begin
                sel_bank_d  = bnk;
                sel_group_d = r[4:3];
                sel_sub_d   = r[2:0];
                case (r[7:5])
                    3'd1: ups_d[7] = 1'b1;
                    3'd2: ups_d[6] = 1'b1;
                    3'd3: ups_d[5] = 1'b1;
                    3'd4: ups_d[4] = 1'b1;
                    3'd7: ups_d[3] = 1'b1;
                    default: ;
                endcase
            end
            if (en_b && chan_hit) begin
                sel_bank_d = bnk;
                // channels 6..8 fold onto subslots 0..2 of group 2
                if (r[3:0] < 4'd3) begin
                    sel_group_d = 2'd0;
                    sel_sub_d   = r[2:0];
                end else if (r[3:0] < 4'd6) begin
                    sel_group_d = 2'd1;
                    sel_sub_d   = r[2:0];
                end else begin
                    sel_group_d = 2'd2;
                    sel_sub_d   = {1'b0, ~&r[2:1], r[0]};
                end
                case (r[7:4])
                    4'hA: ups_d[2] = 1'b1;
                    4'hB: ups_d[1] = 1'b1;
                    4'hC: ups_d[0] = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {selreg_q, host.din};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            selreg_q    <= 9'h0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            din_copy_q  <= 8'h0;
            sel_bank_q  <= 1'b0;
            sel_group_q <= 2'd0;
            sel_sub_q   <= 3'd0;
            ups_q       <= 8'd0;
            clr_q       <= 2'd0;
            bd_q        <= 8'h0;
            wave_mode_q <= 1'b0;
            new_mode_q  <= 1'b0;
            conn_sel_q  <= 6'd0;
            value_a_q   <= 8'h0;
            value_b_q   <= 8'h0;
            load_q      <= 2'd0;
            flagen_q    <= 2'b11;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            selreg_q    <= selreg_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            din_copy_q  <= din_copy_d;
            sel_bank_q  <= sel_bank_d;
            sel_group_q <= sel_group_d;
            sel_sub_q   <= sel_sub_d;
            ups_q       <= ups_d;
            clr_q       <= clr_d;
            bd_q        <= bd_d;
            wave_mode_q <= wave_mode_d;
            new_mode_q  <= new_mode_d;
            conn_sel_q  <= conn_sel_d;
            value_a_q   <= value_a_d;
            value_b_q   <= value_b_d;
            load_q      <= load_d;
            flagen_q    <= flagen_d;
        end
    end

    assign host.busy = busy_q;
    assign host.ovf  = ovf_q;
    assign din_copy  = din_copy_q;
    assign sel_bank  = sel_bank_q;
    assign sel_group = sel_group_q;
    assign sel_sub   = sel_sub_q;
    assign {up_mult, up_ksl_tl, up_ar_dr, up_sl_rr,
            up_wav, up_fnumlo, up_fnumhi, up_fbcon} = ups_q;
    assign {clr_flag_B, clr_flag_A} = clr_q;
    assign {am_dep, vib_dep, rhy_en, rhy_kon} = bd_q;
    assign wave_mode = wave_mode_q;
    assign new_mode  = new_mode_q;
    assign conn_sel  = conn_sel_q;
    assign value_A   = value_a_q;
    assign value_B   = value_b_q;
    assign {load_B, load_A}     = load_q;
    assign {flagen_B, flagen_A} = flagen_q;
endmodule

// File: doc/jtopl3_mmr.md
Name: jtopl3_mmr

Overview:
- Host register front-end for the OPL2/OPL3 core family, generalised to 1 or 2 register banks.
- Host data writes are buffered in a small FIFO and retired at operator-clock rate, one per cenop.
- Each retired write is decoded into per-slot/per-channel update strobes, group/sub/bank selectors and global control registers.
- Sits between the bus interface and jtopl_reg; the clock divider is external and supplies cenop.

Parameters:
- OPL_TYPE, 2, chip flavour: 1=OPL, 2=OPL2, 3=OPL3. Enables wave select (>=2) and bank-1 registers 0x104/0x105 (==3).
- BANKS, 1, register banks: 1 or 2. Must be 2 when OPL_TYPE==3.
- FIFO_DEPTH, 4, data-write queue depth, power of two, 2..16.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- cenop  in  1  operator clock enable; one FIFO pop per cenop
- din  in  8  host data
- write  in  1  host write strobe, one clk wide
- addr  in  2  addr[0]: 0=address, 1=data; addr[1]: bank select, ignored when BANKS==1
- busy  out  1  FIFO full
- ovf  out  1  sticky: a data write was dropped
- din_copy  out  8  data of the last retired write
- sel_bank  out  1  bank of the last retired slot/channel write
- sel_group  out  2  group of the last retired slot/channel write
- sel_sub  out  3  subslot of the last retired slot/channel write
- up_mult, up_ksl_tl, up_ar_dr, up_sl_rr, up_wav, up_fnumlo, up_fnumhi, up_fbcon  out  1 each  update strobes
- rhy_en  out  1  rhythm mode
- rhy_kon  out  5  rhythm key-on bits
- am_dep  out  1  global AM depth
- vib_dep  out  1  global vibrato depth
- wave_mode  out  1  wave select enable
- new_mode  out  1  OPL3 mode
- conn_sel  out  6  4-op connection select
- value_A  out  8  timer A value
- value_B  out  8  timer B value
- load_A, load_B  out  1 each  timer load
- flagen_A, flagen_B  out  1 each  timer flag enable
- clr_flag_A, clr_flag_B  out  1 each  timer flag clear pulse

Behaviour:
- Reset (async):
  - FIFO empty; selreg=9'h0; all strobes, selectors, din_copy, value_A/B and load_A/B = 0.
  - ovf=0; rhy_en=0, rhy_kon=0, am_dep=0, vib_dep=0, wave_mode=0, new_mode=0, conn_sel=0.
  - flagen_A=1, flagen_B=1; busy=0.
- Address write (write && !addr[0]):
  - selreg <= {addr[1] && BANKS==2, din} on the same clk.
  - Not queued; takes effect for subsequent data writes.
- Data write (write && addr[0]):
  - Pushes {selreg, din} if occupancy < FIFO_DEPTH at the start of the cycle; otherwise the write is dropped and ovf <= 1.
  - A pop in the same cycle does not free space for that push.
- busy = (occupancy == FIFO_DEPTH), registered; updates on the clk after the push/pop.
- Pop (cenop && !empty):
  - Removes the oldest entry and decodes it in the same clk.
  - Latency: a write into an empty FIFO is visible at the first cenop clk at least 1 clk after the push.
- Strobes:
  - On every cenop clk, all up_* and clr_flag_* are cleared, then set by the popped entry if any.
  - Each strobe is therefore high for exactly one cenop period.
- Bank gating:
  - Bank-1 entries are discarded (popped, no effect) unless new_mode=1.
  - Exception: 0x104 and 0x105 are always decoded when OPL_TYPE==3.
- Bank-0 globals:
  - 0x01: wave_mode <= din[5] if OPL_TYPE>=2.
  - 0x02: value_A. 0x03: value_B.
  - 0x04: clr_flag_A and clr_flag_B <= din[7]. If !din[7]: flagen_A <= ~din[6], flagen_B <= ~din[5], {load_B, load_A} <= din[1:0].
  - 0xBD: {am_dep, vib_dep, rhy_en, rhy_kon} <= din.
- Bank-1 globals (OPL_TYPE==3 only):
  - 0x104: conn_sel <= din[5:0].
  - 0x105: new_mode <= din[0].
- Slot registers 0x20–0x9F, plus 0xE0–0xFF when OPL_TYPE>=2:
  - Decoded only if r[2:0] <= 5 and r[4:3] != 3.
  - sel_group=r[4:3], sel_sub=r[2:0], sel_bank=bank.
  - Strobe by r[7:5]: 1 up_mult, 2 up_ksl_tl, 3 up_ar_dr, 4 up_sl_rr, 7 up_wav.
- Channel registers 0xA0–0xC8, r[3:0] <= 8:
  - Strobe by r[7:4]: A up_fnumlo, B up_fnumhi, C up_fbcon.
  - sel_group = ch/3.
  - sel_sub = r[2:0] for ch<6; otherwise {0, ~&r[2:1], r[0]}.
  - sel_bank = bank.
- Invalid addresses: popped with no effect; strobes stay low.
- din_copy is updated on every pop.

Test Plan:
- Reset: rst pulse -> busy=0, ovf=0, flagen_A=1, flagen_B=1, all strobes 0.
- Slot write: addr 0x43, data 0x3F, cenop every 4 clk -> one cenop period of up_ksl_tl=1 with sel_group=0, sel_sub=3, din_copy=0x3F.
- Channel write: addr 0xA7, data 0x55 -> up_fnumlo for one cenop period, sel_group=2, sel_sub=3'b001.
- Overflow: FIFO_DEPTH=4, cenop held low, 5 data writes -> busy=1 after the 4th, ovf=1 after the 5th. Then enable cenop -> exactly 4 strobes, in write order.
- Bank gating (OPL_TYPE=3, BANKS=2):
  - bank-1 0x20 with new_mode=0 -> no strobe.
  - write 0x105=0x01, then bank-1 0x20 -> up_mult with sel_bank=1.
- Timer register: 0x04 data 0x80 -> clr_flag_A and clr_flag_B high for one cenop period, flagen_A/B unchanged. Then 0x04 data 0x63 -> flagen_A=0, flagen_B=0, load_A=1, load_B=1.
